// File: rtl/fetch_pc_gen.sv
// Fetch address generator: sequential bundle PCs with branch redirect, post-redirect
// issue blackout, misaligned-target trap and saturating branch-outcome counters.
//
// state | meaning
// IDLE  | held by reset; leaves on the first cycle with rst low
// RUN   | issuing fetch requests, advancing pc on each handshake
// FLUSH | issue blackout after a taken redirect, counting down
// ERROR | misaligned taken target seen; parked until reset
module fetch_pc_gen #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          BUNDLE_BYTES = 16,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        br_valid,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        stall,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    output logic        flush,
    output logic        misalign_err,
    output logic [15:0] taken_cnt,
    output logic [15:0] not_taken_cnt
);

    localparam int OFF_W = $clog2(BUNDLE_BYTES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        ERROR = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic        flush_q, flush_d;
    logic        err_q, err_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] taken_q, taken_d;
    logic [15:0] nt_q, nt_d;

    logic br_take, br_nt, handshake, misaligned;

    assign br_take    = br_valid & br_taken;
    assign br_nt      = br_valid & ~br_taken;
    assign handshake  = valid_q & imem_req_ready;
    assign misaligned = |br_target[OFF_W-1:0];

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        flush_d = 1'b0;
        err_d   = err_q;
        cnt_d   = cnt_q;
        taken_d = taken_q;
        nt_d    = nt_q;

        case (state_q)
            IDLE: begin
                state_d = RUN;
            end
            RUN, FLUSH: begin
                if (br_take && taken_q != 16'hFFFF) taken_d = taken_q + 16'd1;
                if (br_nt && nt_q != 16'hFFFF)      nt_d    = nt_q + 16'd1;

                // A redirect wins over a same-cycle handshake; the flush pulse
                // squashes the bundle accepted in that cycle.
                if (br_take) begin
                    valid_d = 1'b0;
                    if (misaligned) begin
                        err_d   = 1'b1;
                        state_d = ERROR;
                    end else begin
                        pc_d    = br_target;
                        flush_d = 1'b1;
                        cnt_d   = 4'(FLUSH_CYCLES);
                        state_d = FLUSH;
                    end
                end else if (state_q == RUN) begin
                    if (handshake) begin
                        pc_d    = pc_q + 32'(BUNDLE_BYTES);
                        valid_d = ~stall;
                    end else if (!valid_q) begin
                        valid_d = ~stall;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_d == 4'd0) state_d = RUN;
                end
            end
            ERROR: begin
                valid_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            flush_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= 4'd0;
            taken_q <= 16'd0;
            nt_q    <= 16'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            flush_q <= flush_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            taken_q <= taken_d;
            nt_q    <= nt_d;
        end
    end

    assign imem_req_valid = valid_q;
    assign imem_req_addr  = pc_q;
    assign flush          = flush_q;
    assign misalign_err   = err_q;
    assign taken_cnt      = taken_q;
    assign not_taken_cnt  = nt_q;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Bench for fetch_pc_gen: directed scenarios then random traffic, every cycle
// compared against a cycle-level behavioural model of the fetch address stream.
module tb_fetch_pc_gen;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          BB     = 16;
    localparam int          FC     = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        br_valid = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = 32'h0;
    logic        stall = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        flush;
    logic        misalign_err;
    logic [15:0] taken_cnt;
    logic [15:0] not_taken_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    logic [31:0] m_pc;
    logic        m_req, m_fl, m_err, m_idle, m_halt;
    int          m_tk, m_nt, m_wait;

    fetch_pc_gen #(
        .RESET_PC    (RST_PC),
        .BUNDLE_BYTES(BB),
        .FLUSH_CYCLES(FC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .br_valid      (br_valid),
        .br_taken      (br_taken),
        .br_target     (br_target),
        .stall         (stall),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .flush         (flush),
        .misalign_err  (misalign_err),
        .taken_cnt     (taken_cnt),
        .not_taken_cnt (not_taken_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock of the reference behaviour, from the inputs held across the edge.
    task automatic model_edge();
        m_fl = 1'b0;
        if (rst) begin
            m_pc = RST_PC; m_req = 1'b0; m_err = 1'b0;
            m_tk = 0; m_nt = 0; m_wait = 0; m_idle = 1'b1; m_halt = 1'b0;
        end else if (m_idle) begin
            m_idle = 1'b0;
        end else if (!m_halt) begin
            if (br_valid && br_taken) begin
                if (m_tk < 65535) m_tk++;
                m_req = 1'b0;
                if (br_target % BB != 0) begin
                    m_err = 1'b1; m_halt = 1'b1;
                end else begin
                    m_pc = br_target; m_fl = 1'b1; m_wait = FC;
                end
            end else begin
                if (br_valid && m_nt < 65535) m_nt++;
                if (m_wait > 0) m_wait--;
                else if (m_req && imem_req_ready) begin
                    m_pc  = m_pc + BB;
                    m_req = !stall;
                end else if (!m_req) m_req = !stall;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("valid", 32'(imem_req_valid), 32'(m_req));
        chk("addr",  imem_req_addr, m_pc);
        chk("flush", 32'(flush), 32'(m_fl));
        chk("err",   32'(misalign_err), 32'(m_err));
        chk("taken", 32'(taken_cnt), 32'(m_tk));
        chk("ntkn",  32'(not_taken_cnt), 32'(m_nt));
    endtask

    task automatic redirect(input logic [31:0] tgt);
        br_valid = 1'b1; br_taken = 1'b1; br_target = tgt;
        step();
        br_valid = 1'b0; br_taken = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int k = 0;
        while (!imem_req_valid && k < 20) begin
            step();
            k++;
        end
        if (!imem_req_valid) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: valid never rose within 20 cycles", tag);
        end
    endtask

    initial begin
        rst = 1'b1;
        step(); step();
        chk("rst_addr", imem_req_addr, 32'h0);
        chk("rst_valid", 32'(imem_req_valid), 32'h0);

        // reset release: valid rises 2 cycles later, sequential bundles
        rst = 1'b0; stall = 1'b0; imem_req_ready = 1'b1;
        step();
        chk("rel_c1_valid", 32'(imem_req_valid), 32'h0);
        step();
        chk("rel_c2_addr", imem_req_addr, 32'h0);
        chk("rel_c2_valid", 32'(imem_req_valid), 32'h1);
        step(); chk("seq_10", imem_req_addr, 32'h10);
        step(); chk("seq_20", imem_req_addr, 32'h20);

        // hold 0x20 under ready=0 with stall
        imem_req_ready = 1'b0; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_addr", imem_req_addr, 32'h20);
            chk("hold_valid", 32'(imem_req_valid), 32'h1);
        end
        imem_req_ready = 1'b1;
        step();
        chk("post_hs_valid", 32'(imem_req_valid), 32'h0);
        step();
        chk("stalled_valid", 32'(imem_req_valid), 32'h0);
        stall = 1'b0;
        step(); chk("resume_30", imem_req_addr, 32'h30);
        step(); chk("seq_40", imem_req_addr, 32'h40);

        // redirect colliding with handshake at 0x40
        redirect(32'h100);
        chk("rd_flush", 32'(flush), 32'h1);
        chk("rd_addr", imem_req_addr, 32'h100);
        step();
        chk("rd_flush_once", 32'(flush), 32'h0);
        wait_valid("rd_wait");
        chk("rd_first", imem_req_addr, 32'h100);

        // not-taken leaves stream alone
        br_valid = 1'b1; br_taken = 1'b0;
        step();
        br_valid = 1'b0;
        chk("nt_cnt", 32'(not_taken_cnt), 32'h1);
        step(); step();

        // wrap-around
        redirect(32'hFFFF_FFF0);
        wait_valid("wrap_wait");
        chk("wrap_pre", imem_req_addr, 32'hFFFF_FFF0);
        step();
        chk("wrap_addr", imem_req_addr, 32'h0);

        // back-to-back redirects
        redirect(32'h100);
        step();
        redirect(32'h200);
        chk("b2b_flush", 32'(flush), 32'h1);
        wait_valid("b2b_wait");
        chk("b2b_first", imem_req_addr, 32'h200);
        step();

        // misaligned target traps
        redirect(32'h104);
        chk("mis_err", 32'(misalign_err), 32'h1);
        chk("mis_noflush", 32'(flush), 32'h0);
        for (int i = 0; i < 4; i++) begin
            br_valid = 1'b1; br_taken = i[0]; br_target = 32'h300;
            step();
        end
        br_valid = 1'b0;
        chk("err_valid", 32'(imem_req_valid), 32'h0);
        rst = 1'b1;
        step();
        chk("rst_err", 32'(misalign_err), 32'h0);
        chk("rst_tk", 32'(taken_cnt), 32'h0);
        rst = 1'b0;

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] t;
            stall          = ($urandom_range(0, 3) == 0);
            imem_req_ready = ($urandom_range(0, 3) != 0);
            br_valid       = ($urandom_range(0, 5) == 0);
            br_taken       = $urandom_range(0, 1) == 1;
            t              = $urandom & 32'hFFFF_FFF0;
            if ($urandom_range(0, 150) == 0) t = t | 32'h8;
            br_target      = t;
            rst            = ($urandom_range(0, 300) == 0);
            step();
        end
        rst = 1'b0; br_valid = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
